// File: rtl/mips_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the register-file write-back path.
//   REG_ADDR_W : width of a register-file address (32 registers)
//   DATA_W     : width of a register-file data word
//   REG_ZERO   : the hard-wired $zero register, never written
//   wb_req_t   : one pending write-back {destination register, data}
// ---------------------------------------------------------------------------
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // The destination field is called addr because "reg" is a reserved word.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  // True when a destination is $zero; such writes are architecturally void.
  function automatic logic isZeroReg(input logic [REG_ADDR_W-1:0] r);
    return (r == REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// In-order circular buffer of pending register writes with two push lanes
// and one pop lane. Lane 0 is always stored ahead of lane 1 when both push
// in the same cycle. The occupancy vector and per-entry destination
// addresses are exported so the scoreboard can search the whole queue.
//
// Ports
//   clk, reset     : clock and synchronous active-high reset
//   push0Valid_i   : enqueue push0_i this edge (older of the two)
//   push0_i        : request for lane 0
//   push1Valid_i   : enqueue push1_i this edge (younger of the two)
//   push1_i        : request for lane 1
//   pop_i          : remove the head entry this edge (ignored when empty)
//   count_o        : number of occupied entries
//   head_o         : oldest entry
//   occupied_o     : per-slot valid flag, indexed by physical slot
//   entryAddr_o    : per-slot destination register, indexed by physical slot
//
// The caller must never push more entries than there is free space.
// DEPTH must be a power of two so the pointers wrap for free.
// ---------------------------------------------------------------------------
module wb_fifo
  import mips_pkg::*;
#(
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_QW = PTR_W + 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push0Valid_i,
  input  wb_req_t                           push0_i,
  input  logic                              push1Valid_i,
  input  wb_req_t                           push1_i,
  input  logic                              pop_i,
  output logic [CNT_QW-1:0]                 count_o,
  output wb_req_t                           head_o,
  output logic [DEPTH-1:0]                  occupied_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]  entryAddr_o
);

  wb_req_t           entries_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_QW-1:0] count_q, count_d;
  logic [PTR_W-1:0]  slot1;
  logic              popEn;

  // A pop request against an empty queue is dropped so count never underflows.
  assign popEn = pop_i & (count_q != '0);

  // Lane 1 lands right behind lane 0 when both push, otherwise it takes the
  // write pointer slot itself so the queue stays dense.
  assign slot1 = wrPtr_q + PTR_W'(push0Valid_i);

  // Next-state pointers and count. Push and pop can coincide; the count
  // alone tells full from empty because the pointers are equal in both.
  always_comb begin
    wrPtr_d = wrPtr_q + PTR_W'(push0Valid_i) + PTR_W'(push1Valid_i);
    rdPtr_d = rdPtr_q + PTR_W'(popEn);
    count_d = count_q + CNT_QW'(push0Valid_i) + CNT_QW'(push1Valid_i)
              - CNT_QW'(popEn);
  end

  // Pointer and count registers. Reset empties the queue, which is all it
  // takes to discard every buffered write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Entry storage. Contents are only meaningful where occupied, so the
  // array carries no reset.
  always_ff @(posedge clk) begin
    if (push0Valid_i) begin
      entries_q[wrPtr_q] <= push0_i;
    end
    if (push1Valid_i) begin
      entries_q[slot1] <= push1_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = entries_q[rdPtr_q];

  // A physical slot is occupied when its distance from the read pointer,
  // taken modulo DEPTH, is below the current count.
  for (genvar g = 0; g < DEPTH; g++) begin : gSlot
    logic [PTR_W-1:0] offset;
    assign offset         = PTR_W'(g) - rdPtr_q;
    assign occupied_o[g]  = ({1'b0, offset} < count_q);
    assign entryAddr_o[g] = entries_q[g].addr;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the register file's single write port between the ALU and the
// load write-back paths. Accepted writes go into an in-order queue and are
// issued one per cycle through registered RegWrite/WriteReg/WriteData. A
// scoreboard flags decode source registers that still have a write in
// flight, and a saturating counter records back-pressure cycles.
//
// Ports
//   clk, reset            : clock and synchronous active-high reset
//   alu_valid/reg/data    : ALU write-back request
//   alu_ready             : ALU request accepted when high with alu_valid
//   mem_valid/reg/data    : load write-back request
//   mem_ready             : load request accepted when high with mem_valid
//   ReadReg1, ReadReg2    : decode source registers to look up
//   pend1, pend2          : source register has an uncommitted write
//   RegWrite/WriteReg/
//   WriteData             : register-file write port, registered
//   stall_cnt             : saturating count of back-pressure cycles
// ---------------------------------------------------------------------------
module regfile_wb_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  mem_valid,
  input  logic [REG_ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]     mem_data,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] ReadReg1,
  input  logic [REG_ADDR_W-1:0] ReadReg2,
  output logic                  pend1,
  output logic                  pend2,
  output logic                  RegWrite,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_QW = PTR_W + 1;

  logic [CNT_QW-1:0]                count;
  logic [CNT_QW-1:0]                freeSlots;
  logic                             memFire, aluFire;
  logic                             memPush, aluPush;
  logic                             issue;
  logic                             stallEvent;
  wb_req_t                          memReq, aluReq, head;
  logic [DEPTH-1:0]                 occupied;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] entryAddr;
  logic                             hit1, hit2;

  logic                  regWrite_q;
  logic [REG_ADDR_W-1:0] writeReg_q;
  logic [DATA_W-1:0]     writeData_q;
  logic [CNT_W-1:0]      stallCnt_q, stallCnt_d;

  // Free space is judged on the count before the edge; an issue happening
  // on the same edge does not make room early. The load always gets the
  // last free slot because it is the older instruction, so the ALU only
  // takes a lone slot when no load is competing for it. Neither ready
  // looks at alu_valid, which keeps the handshake free of loops.
  assign freeSlots = CNT_QW'(DEPTH) - count;
  assign mem_ready = (freeSlots >= CNT_QW'(1));
  assign alu_ready = (freeSlots >= CNT_QW'(2)) |
                     ((freeSlots >= CNT_QW'(1)) & ~mem_valid);

  assign memFire = mem_valid & mem_ready;
  assign aluFire = alu_valid & alu_ready;

  // Writes to $zero complete the handshake but are never queued, so they
  // consume no slot and produce no register-file write.
  assign memPush = memFire & ~isZeroReg(mem_reg);
  assign aluPush = aluFire & ~isZeroReg(alu_reg);

  assign memReq = '{addr: mem_reg, data: mem_data};
  assign aluReq = '{addr: alu_reg, data: alu_data};

  assign issue = (count != '0);

  // Load on lane 0, ALU on lane 1: when both arrive together the load is
  // queued first, preserving program order.
  wb_fifo #(
    .DEPTH (DEPTH)
  ) uFifo (
    .clk          (clk),
    .reset        (reset),
    .push0Valid_i (memPush),
    .push0_i      (memReq),
    .push1Valid_i (aluPush),
    .push1_i      (aluReq),
    .pop_i        (issue),
    .count_o      (count),
    .head_o       (head),
    .occupied_o   (occupied),
    .entryAddr_o  (entryAddr)
  );

  // Register-file write port. Every edge with a non-empty queue issues the
  // head; otherwise the enable drops while address and data keep their
  // last values. Reset clears the queue too, so no stale pulse follows it.
  always_ff @(posedge clk) begin
    if (reset) begin
      regWrite_q  <= 1'b0;
      writeReg_q  <= REG_ZERO;
      writeData_q <= '0;
    end else if (issue) begin
      regWrite_q  <= 1'b1;
      writeReg_q  <= head.addr;
      writeData_q <= head.data;
    end else begin
      regWrite_q  <= 1'b0;
    end
  end

  assign RegWrite  = regWrite_q;
  assign WriteReg  = writeReg_q;
  assign WriteData = writeData_q;

  // Back-pressure is any requester holding valid without ready. The
  // counter sticks at all-ones instead of wrapping.
  assign stallEvent = (alu_valid & ~alu_ready) | (mem_valid & ~mem_ready);

  always_comb begin
    stallCnt_d = stallCnt_q;
    if (stallEvent && (stallCnt_q != '1)) begin
      stallCnt_d = stallCnt_q + CNT_W'(1);
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt_q <= '0;
    end else begin
      stallCnt_q <= stallCnt_d;
    end
  end

  assign stall_cnt = stallCnt_q;

  // Scoreboard search: the write currently on the register-file port plus
  // every occupied queue slot. Requests arriving this cycle are not seen;
  // they show up in the lookup one cycle later once they are queued.
  always_comb begin
    hit1 = regWrite_q && (writeReg_q == ReadReg1);
    hit2 = regWrite_q && (writeReg_q == ReadReg2);
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | (occupied[i] && (entryAddr[i] == ReadReg1));
      hit2 = hit2 | (occupied[i] && (entryAddr[i] == ReadReg2));
    end
  end

  // $zero is never pending, whatever stale address a free slot may hold.
  assign pend1 = hit1 & ~isZeroReg(ReadReg1);
  assign pend2 = hit2 & ~isZeroReg(ReadReg2);

endmodule
